// File: rtl/worker_rr_dispatch.sv
// Round-robin job dispatcher for the Julia worker array.
// Each accepted job is issued to one worker. The rotating one-hot mask selects the worker, either in strict rotation or by skip-busy search.
module worker_rr_dispatch #(
  parameter int unsigned NUM_WRK = 16,
  parameter int unsigned JOB_W   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       skip_busy,
  input  logic                       job_valid,
  input  logic [JOB_W-1:0]           job_data,
  output logic                       job_ready,
  input  logic [NUM_WRK-1:0]         wrk_idle,
  output logic [NUM_WRK-1:0]         wrk_start,
  output logic [JOB_W-1:0]           wrk_job,
  output logic [$clog2(NUM_WRK)-1:0] grant_idx,
  output logic [NUM_WRK-1:0]         mask,
  input  logic                       count_clr,
  output logic [CNT_W-1:0]           dispatch_count,
  output logic                       all_idle
);

  localparam int unsigned IDX_W = $clog2(NUM_WRK);

  logic [NUM_WRK-1:0] r_mask;
  logic [NUM_WRK-1:0] r_wrk_start;
  logic [JOB_W-1:0]   r_wrk_job;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [CNT_W-1:0]   r_count;
  logic               r_all_idle;

  logic [NUM_WRK-1:0] w_elig;
  logic [IDX_W-1:0]   w_ptr;
  logic               w_cand_vld;
  logic [IDX_W-1:0]   w_cand_idx;
  logic [NUM_WRK-1:0] w_cand_oh;
  logic [NUM_WRK-1:0] w_mask_nxt;
  int unsigned        w_pos;
  logic               w_fire;

  // A worker pulsed last cycle may still show idle; exclude it from selection.
  assign w_elig = wrk_idle & ~r_wrk_start;

  always_comb begin
    w_ptr = '0;
    for (int i = 0; i < NUM_WRK; i++) begin
      if (r_mask[i]) w_ptr = w_ptr | IDX_W'(i);
    end
  end

  // Candidate selection. In skip-busy mode, search upward from the pointer and wrap to worker 0.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_idx = '0;
    w_pos      = 0;
    if (!skip_busy) begin
      w_cand_vld = w_elig[w_ptr];
      w_cand_idx = w_ptr;
    end else begin
      for (int unsigned k = 0; k < NUM_WRK; k++) begin
        w_pos = 32'(w_ptr) + k;
        if (w_pos >= NUM_WRK) w_pos = w_pos - NUM_WRK;
        if (!w_cand_vld && w_elig[IDX_W'(w_pos)]) begin
          w_cand_vld = 1'b1;
          w_cand_idx = IDX_W'(w_pos);
        end
      end
    end
  end

  assign w_cand_oh  = w_cand_vld ? (NUM_WRK'(1) << w_cand_idx) : '0;
  assign w_mask_nxt = {w_cand_oh[NUM_WRK-2:0], w_cand_oh[NUM_WRK-1]};
  assign job_ready  = w_cand_vld & ~rst;
  assign w_fire     = job_valid & job_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask      <= NUM_WRK'(1);
      r_wrk_start <= '0;
      r_wrk_job   <= '0;
      r_grant_idx <= '0;
      r_count     <= '0;
      r_all_idle  <= 1'b0;
    end else begin
      r_all_idle <= (&wrk_idle) & ~(|r_wrk_start);
      if (w_fire) begin
        r_wrk_start <= w_cand_oh;
        r_wrk_job   <= job_data;
        r_grant_idx <= w_cand_idx;
        r_mask      <= w_mask_nxt;
      end else begin
        r_wrk_start <= '0;
      end
      if (count_clr)   r_count <= '0;
      else if (w_fire) r_count <= r_count + CNT_W'(1);
    end
  end

  assign wrk_start      = r_wrk_start;
  assign wrk_job        = r_wrk_job;
  assign grant_idx      = r_grant_idx;
  assign mask           = r_mask;
  assign dispatch_count = r_count;
  assign all_idle       = r_all_idle;

endmodule

// File: doc/worker_rr_dispatch.md
Name: worker_rr_dispatch

Overview:
- Round-robin job dispatcher for the Julia worker array.
- Accepts jobs (pixel/tile descriptors) over a valid/ready handshake and issues each one to exactly one worker.
- Keeps a one-hot rotating priority mask. Two modes: strict rotation, or skip-busy (search forward for the next idle worker).
- Sits between the job generator and the NUM_WRK worker instances; replaces the bare rotating-mask generator.

Parameters:
- NUM_WRK, 16, number of Julia workers (>=2)
- JOB_W, 32, job descriptor width in bits
- CNT_W, 16, dispatch counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- skip_busy  in  1  0 = strict rotate, 1 = skip-busy search
- job_valid  in  1  job source has a descriptor
- job_data  in  JOB_W  job descriptor
- job_ready  out  1  dispatcher accepts job this cycle
- wrk_idle  in  NUM_WRK  per-worker idle flags
- wrk_start  out  NUM_WRK  one-hot, one-cycle start pulse
- wrk_job  out  JOB_W  descriptor presented to workers; valid while wrk_start is nonzero
- grant_idx  out  $clog2(NUM_WRK)  index of the last granted worker
- mask  out  NUM_WRK  one-hot priority pointer (next worker to consider)
- count_clr  in  1  synchronous clear of dispatch_count
- dispatch_count  out  CNT_W  total jobs dispatched, wraps modulo 2^CNT_W
- all_idle  out  1  registered AND of wrk_idle with wrk_start==0

Behaviour:
- Reset (async, rst=1) values:
  - mask = 1 (bit 0)
  - wrk_start = 0, wrk_job = 0, grant_idx = 0, dispatch_count = 0, all_idle = 0
  - job_ready = 0 while rst is high
- eligible = wrk_idle & ~wrk_start.
  - A worker pulsed last cycle is never re-granted the next cycle.
  - Workers must drop wrk_idle no later than one cycle after their wrk_start.
- Candidate selection (combinational):
  - Strict (skip_busy=0): candidate = mask, only if eligible at the mask bit; otherwise no candidate.
  - Skip-busy (skip_busy=1): candidate = first eligible bit searching from the mask position upward, inclusive, wrapping from NUM_WRK-1 to 0. No eligible bit means no candidate.
- job_ready = candidate exists. It is combinational from mask, wrk_idle, wrk_start and skip_busy, and has no dependence on job_valid.
- Dispatch occurs when job_valid & job_ready at a clock edge. At that edge:
  - wrk_start <= candidate one-hot, for one cycle only.
  - wrk_job <= job_data.
  - grant_idx <= candidate index.
  - mask <= candidate rotated left by 1 (bit NUM_WRK-1 wraps to bit 0).
  - dispatch_count increments.
- No dispatch:
  - wrk_start <= 0.
  - wrk_job, grant_idx and mask hold.
  - In strict mode a busy pointer worker stalls the stream; the pointer does not advance.
- Latency: exactly 1 cycle from the accepting edge to the wrk_start pulse. Sustained throughput is 1 job/cycle while enough workers are eligible.
- Mode change takes effect on the next selection. The mask is not reset by a mode change.
- count_clr has priority over increment: a same-cycle dispatch leaves the count at 0. Increment wraps from 2^CNT_W-1 to 0.
- all_idle <= &wrk_idle & ~|wrk_start, registered.
- Reset mid-operation:
  - Any pending wrk_start pulse is cancelled immediately.
  - A job presented during reset is not accepted.
  - The first cycle after reset release considers worker 0 first.
- Invariants:
  - mask is always exactly one-hot.
  - wrk_start has at most one bit set.
  - wrk_start is never set for a worker whose wrk_idle was 0 at the accepting edge.

Test Plan:
- Reset: assert rst mid-stream with wrk_start=0x0004 -> wrk_start=0 and mask=0x0001 immediately; dispatch_count=0; job_ready=0 until rst deasserts.
- Strict rotate, all idle (workers drop idle the cycle after start, re-raise 4 cycles later), job_valid held, NUM_WRK=16 -> grants 0,1,...,15,0; mask ends at 0x0002; dispatch_count=17.
- Strict stall: mask=0x0008, wrk_idle[3]=0, others 1 -> job_ready=0 and mask held. Raise wrk_idle[3] -> job accepted, wrk_start=0x0008 next cycle, mask=0x0010.
- Skip-busy search: mask=0x0008, wrk_idle=0xFFE7 (3,4 busy) -> grant_idx=5, wrk_start=0x0020, mask=0x0040, wrk_job equals accepted job_data.
- Skip-busy wrap: mask=0x8000, wrk_idle=0x0001 -> grant 0, mask=0x0002. On the next cycle, with wrk_idle still 0x0001 -> job_ready=0, showing the start-exclusion rule.
- Counter: preload dispatch_count to 0xFFFF via 65535 dispatches, then one more -> 0x0000. count_clr coincident with a dispatch -> 0x0000.
